// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: shared defaults and helpers for the pipeline register chain
package pipe_stage_chain_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 3;
  // Population count of up to 32 stage-valid bits.
  function automatic logic [5:0] count_ones(input logic [31:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: upstream/downstream handshake, flush and status bundle of the chain
interface pipe_stage_chain_if
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [CW-1:0]    occupancy;
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, stage_valid, occupancy
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, stage_valid, occupancy
  );
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// pipe_slot: one valid/data register pair with flush-aware load and local ready
module pipe_slot
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             rdy_dn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             rdy_o,
  output logic             ev_o,
  output logic             v_o,
  output logic             v_d_o,
  output logic [WIDTH-1:0] d_o
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  // A killed or empty slot is always ready, so it reloads (possibly with a bubble) and thereby empties.
  always_comb begin
    ev_o  = v_q & ~flush_i;
    rdy_o = ~ev_o | rdy_dn_i;
    v_d   = rdy_o ? valid_i : v_q;
    d_d   = rdy_o ? data_i : d_q;
  end
  // Slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign v_o   = v_q;
  assign v_d_o = v_d;
  assign d_o   = d_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready register chain with bubble collapse and per-stage flush
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_chain_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] ev, v, v_d, up_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  assign rdy[DEPTH] = bus.out_ready;
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign up_v[g] = bus.in_valid;
      assign up_d[g] = bus.in_data;
    end else begin : g_body
      assign up_v[g] = ev[g-1];
      assign up_d[g] = d[g-1];
    end
    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush_i  (bus.flush[g]),
      .rdy_dn_i (rdy[g+1]),
      .valid_i  (up_v[g]),
      .data_i   (up_d[g]),
      .rdy_o    (rdy[g]),
      .ev_o     (ev[g]),
      .v_o      (v[g]),
      .v_d_o    (v_d[g]),
      .d_o      (d[g])
    );
  end
  // Occupancy tracks the number of valid stages after the coming edge.
  always_comb occ_d = CW'(count_ones(32'(v_d)));
  // Registered occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end
  assign bus.in_ready    = rdy[0];
  assign bus.out_valid   = ev[DEPTH-1];
  assign bus.out_data    = d[DEPTH-1];
  assign bus.stage_valid = v;
  assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed vector bench for pipe_stage_chain (DEPTH=3, WIDTH=32)
module tb_pipe_stage_chain;
  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic [2:0]  fl;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [2:0]  sv;
    logic [1:0]  occ;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(3)) bus();
  pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] din, input logic ordy, input logic [2:0] fl,
                     input logic ir, input logic ov, input logic [31:0] od, input logic [2:0] sv,
                     input logic [1:0] occ);
    vecs.push_back('{iv, din, ordy, fl, ir, ov, od, sv, occ});
  endtask

  task automatic drive(input logic iv, input logic [31:0] din, input logic ordy, input logic [2:0] fl);
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  initial begin
    // streaming 1..8, out_ready high
    add(1, 1, 1, 0, 1, 0, 0, 3'b000, 0);
    add(1, 2, 1, 0, 1, 0, 0, 3'b001, 1);
    add(1, 3, 1, 0, 1, 0, 0, 3'b011, 2);
    for (int k = 3; k <= 7; k++) add(1, 32'(k + 1), 1, 0, 1, 1, 32'(k - 2), 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 6, 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 7, 3'b110, 2);
    add(0, 0, 1, 0, 1, 1, 8, 3'b100, 1);
    add(0, 0, 1, 0, 1, 0, 0, 3'b000, 0);
    // backpressure A,B,C with 4 stalled cycles
    add(1, 32'hA, 0, 0, 1, 0, 0, 3'b000, 0);
    add(1, 32'hB, 0, 0, 1, 0, 0, 3'b001, 1);
    add(1, 32'hC, 0, 0, 1, 0, 0, 3'b011, 2);
    for (int k = 0; k < 4; k++) add(0, 32'hD, 0, 0, 0, 1, 32'hA, 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 32'hA, 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 32'hB, 3'b110, 2);
    add(0, 0, 1, 0, 1, 1, 32'hC, 3'b100, 1);
    // bubble collapse 5,6,7 under stall, then flush[0] with new beat 9
    add(1, 5, 0, 0, 1, 0, 0, 3'b000, 0);
    add(1, 6, 0, 0, 1, 0, 0, 3'b001, 1);
    add(1, 7, 0, 0, 1, 0, 0, 3'b011, 2);
    add(0, 0, 0, 0, 0, 1, 5, 3'b111, 3);
    add(1, 9, 0, 3'b001, 1, 1, 5, 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 5, 3'b111, 3);
    add(0, 0, 1, 0, 1, 1, 6, 3'b110, 2);
    add(0, 0, 1, 0, 1, 1, 9, 3'b100, 1);
    // flush 3'b011 with 1,2,3 loaded
    add(1, 1, 0, 0, 1, 0, 0, 3'b000, 0);
    add(1, 2, 0, 0, 1, 0, 0, 3'b001, 1);
    add(1, 3, 0, 0, 1, 0, 0, 3'b011, 2);
    add(0, 0, 0, 3'b011, 1, 1, 1, 3'b111, 3);
    add(0, 0, 0, 0, 1, 1, 1, 3'b100, 1);
    add(0, 0, 1, 0, 1, 1, 1, 3'b100, 1);
    // flush all ones while a new beat enters
    add(1, 32'h11, 0, 0, 1, 0, 0, 3'b000, 0);
    add(1, 32'h12, 0, 0, 1, 0, 0, 3'b001, 1);
    add(1, 32'h13, 0, 0, 1, 0, 0, 3'b011, 2);
    add(1, 32'h14, 0, 3'b111, 1, 0, 0, 3'b111, 3);
    add(0, 0, 1, 0, 1, 0, 0, 3'b001, 1);
    add(0, 0, 1, 0, 1, 0, 0, 3'b010, 1);
    add(0, 0, 1, 0, 1, 1, 32'h14, 3'b100, 1);
    add(0, 0, 1, 0, 1, 0, 0, 3'b000, 0);

    drive(0, 0, 0, 0);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_stage_valid", 32'(bus.stage_valid), 0);
    chk("rst_occupancy", 32'(bus.occupancy), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) chk($sformatf("v%0d_out_data", i), bus.out_data, vecs[i].od);
      chk($sformatf("v%0d_stage_valid", i), 32'(bus.stage_valid), 32'(vecs[i].sv));
      chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(vecs[i].occ));
      @(posedge clk); #1;
    end

    // async reset mid-stream with a full chain
    drive(1, 32'h21, 0, 0);
    @(posedge clk); #1;
    bus.in_data = 32'h22;
    @(posedge clk); #1;
    bus.in_data = 32'h23;
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    #1;
    chk("pre_rst_full", 32'(bus.stage_valid), 3'b111);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_stage_valid", 32'(bus.stage_valid), 0);
    chk("async_occupancy", 32'(bus.occupancy), 0);
    chk("async_in_ready", 32'(bus.in_ready), 1);
    chk("async_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    chk("held_rst_stage_valid", 32'(bus.stage_valid), 0);
    #2;
    reset = 1'b0;
    drive(1, 32'h30, 1, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_c%0d_out_valid", c), 32'(bus.out_valid), 32'(c == 3));
      if (c == 3) chk("post_rst_out_data", bus.out_data, 32'h30);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
